// File: rtl/ntt_pkg.sv
// Shared NTT definitions: loader FSM states, width helpers and the bit-reversal
// function that the twiddle-address generator also uses.
package ntt_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} load_state_t;

  localparam int MAX_REV_W = 32;

  function automatic int log_n(input int ring_size);
    return $clog2(ring_size);
  endfunction

  function automatic int addr_w(input int ring_size, input int num_banks);
    return $clog2(ring_size) - $clog2(num_banks);
  endfunction

  // Mirrors the low 'width' bits of x; bits at and above 'width' come back as zero.
  function automatic logic [MAX_REV_W-1:0] bit_rev(input logic [MAX_REV_W-1:0] x,
                                                   input int width);
    logic [MAX_REV_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_REV_W; i++) begin
      if (i < width) r[i] = x[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_reverse_loader.sv
// Streams one frame of coefficients into NUM_BANKS RAM banks, placing each
// coefficient at its bit-reversed (or natural) index.
module bit_reverse_loader
  import ntt_pkg::*;
#(
  parameter  int RING_SIZE  = 256,
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_BANKS  = 2,
  localparam int LOG_N      = log_n(RING_SIZE),
  localparam int LOG_B      = $clog2(NUM_BANKS),
  localparam int ADDR_W     = addr_w(RING_SIZE, NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode_bitrev,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [NUM_BANKS-1:0]  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [LOG_N-1:0] LAST_COUNT = LOG_N'(RING_SIZE - 1);

  load_state_t           state_q;
  logic [LOG_N-1:0]      count_q;
  logic                  mode_q;
  logic                  in_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic [NUM_BANKS-1:0]  wr_en_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic [LOG_N-1:0]      idx_d;
  logic [LOG_B-1:0]      bank_d;
  logic [NUM_BANKS-1:0]  wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_d;
  logic                  accept;

  assign accept = in_valid & in_ready_q;

  // Bank is the top LOG_B bits of the placement index, address the rest.
  always_comb begin
    idx_d     = mode_q ? LOG_N'(bit_rev(MAX_REV_W'(count_q), LOG_N)) : count_q;
    bank_d    = idx_d[LOG_N-1 -: LOG_B];
    wr_addr_d = idx_d[ADDR_W-1:0];
    wr_en_d   = '0;
    wr_en_d[bank_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      mode_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_en_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            count_q    <= '0;
            mode_q     <= mode_bitrev;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= in_data;
            // The final write lands together with done, so ready drops here.
            if (count_q == LAST_COUNT) begin
              state_q    <= FLUSH;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_bit_reverse_loader.sv
// Scoreboard bench for bit_reverse_loader: an 8-entry/2-bank instance for most
// scenarios and a 16-entry/4-bank instance for the wider bank decode.
module tb_bit_reverse_loader;

  typedef struct {
    logic [3:0]  en;
    logic [1:0]  addr;
    logic [31:0] data;
  } expWrite_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start, mode_bitrev, in_valid, in_ready, busy, done;
  logic [31:0] in_data, wr_data;
  logic [1:0]  wr_en, wr_addr;

  logic        start16, mode16, valid16, ready16, busy16, done16;
  logic [31:0] data16, wrData16;
  logic [3:0]  wrEn16;
  logic [1:0]  wrAddr16;

  int testsRun  = 0;
  int failCount = 0;

  expWrite_t sb8[$];
  expWrite_t sb16[$];
  expWrite_t e8, e16;
  bit acceptDrv8 = 1'b0, acceptDrv16 = 1'b0;
  bit sampled8 = 1'b0, sampled16 = 1'b0;

  bit_reverse_loader #(.RING_SIZE(8), .DATA_WIDTH(32), .NUM_BANKS(2)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start), .mode_bitrev(mode_bitrev),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  bit_reverse_loader #(.RING_SIZE(16), .DATA_WIDTH(32), .NUM_BANKS(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .mode_bitrev(mode16),
    .in_valid(valid16), .in_ready(ready16), .in_data(data16),
    .wr_en(wrEn16), .wr_addr(wrAddr16), .wr_data(wrData16), .busy(busy16), .done(done16)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference placement: reverse LOG_N bits (or not), then split into bank and address.
  function automatic expWrite_t modelWrite(input int k, input int logN, input int logB,
                                           input bit mode, input logic [31:0] data);
    expWrite_t e;
    int r, idx;
    r = 0;
    for (int i = 0; i < logN; i++) r |= ((k >> (logN - 1 - i)) & 1) << i;
    idx    = mode ? r : k;
    e.en   = 4'(1 << (idx >> (logN - logB)));
    e.addr = 2'(idx & ((1 << (logN - logB)) - 1));
    e.data = data;
    return e;
  endfunction

  always @(posedge clk) begin
    sampled8  <= acceptDrv8;
    sampled16 <= acceptDrv16;
  end

  always @(negedge clk) begin
    if (sampled8) begin
      if (sb8.size() == 0) checkOutput("sb8Underflow", 64'd1, 64'd0);
      else begin
        e8 = sb8.pop_front();
        checkOutput("wrEn8", 64'(wr_en), 64'(e8.en));
        checkOutput("wrAddr8", 64'(wr_addr), 64'(e8.addr));
        checkOutput("wrData8", 64'(wr_data), 64'(e8.data));
      end
    end else begin
      checkOutput("wrEn8Idle", 64'(wr_en), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (sampled16) begin
      if (sb16.size() == 0) checkOutput("sb16Underflow", 64'd1, 64'd0);
      else begin
        e16 = sb16.pop_front();
        checkOutput("wrEn16", 64'(wrEn16), 64'(e16.en));
        checkOutput("wrAddr16", 64'(wrAddr16), 64'(e16.addr));
        checkOutput("wrData16", 64'(wrData16), 64'(e16.data));
      end
    end else begin
      checkOutput("wrEn16Idle", 64'(wrEn16), 64'd0);
    end
  end

  // Drives one frame into the 8-entry instance; stopAfter < 8 leaves it mid-frame.
  task automatic applyStimulus(input bit mode, input logic [31:0] base, input int gapMax,
                               input bit disturb, input int stopAfter);
    int gaps;
    @(posedge clk); #1;
    start = 1'b1; mode_bitrev = mode;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < stopAfter; k++) begin
      gaps = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
      repeat (gaps) begin
        in_valid = 1'b0; acceptDrv8 = 1'b0; in_data = $urandom;
        if (disturb) begin start = 1'b1; mode_bitrev = ~mode_bitrev; end
        @(posedge clk); #1;
        start = 1'b0;
      end
      in_valid = 1'b1; in_data = base + 32'(k); acceptDrv8 = 1'b1;
      sb8.push_back(modelWrite(k, 3, 1, mode, base + 32'(k)));
      if (disturb && k == 4) begin start = 1'b1; mode_bitrev = ~mode; end
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0; acceptDrv8 = 1'b0;
    if (stopAfter < 8) return;
    if (disturb) begin start = 1'b1; mode_bitrev = ~mode; end
    @(negedge clk);
    checkOutput("doneLastWrite", 64'(done), 64'd1);
    checkOutput("busyFlush", 64'(busy), 64'd1);
    checkOutput("readyFlush", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("donePulse", 64'(done), 64'd0);
    checkOutput("busyIdle", 64'(busy), 64'd0);
    checkOutput("readyIdle", 64'(in_ready), 64'd0);
    checkOutput("sb8Drained", 64'(sb8.size()), 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "WrEn"}, 64'(wr_en), 64'd0);
    checkOutput({tag, "WrAddr"}, 64'(wr_addr), 64'd0);
    checkOutput({tag, "WrData"}, 64'(wr_data), 64'd0);
    checkOutput({tag, "Busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "Done"}, 64'(done), 64'd0);
    checkOutput({tag, "Ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start = 1'b0; mode_bitrev = 1'b0; in_valid = 1'b0; in_data = '0;
    start16 = 1'b0; mode16 = 1'b1; valid16 = 1'b0; data16 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    reset_n = 1'b1;

    $display("[TB] bit-reversed frame, back-to-back");
    applyStimulus(1'b1, 32'd0, 0, 1'b0, 8);

    $display("[TB] natural frame");
    applyStimulus(1'b0, 32'hA000_0000, 0, 1'b0, 8);

    $display("[TB] 16-entry, 4-bank bit-reversed frame");
    @(posedge clk); #1;
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      valid16 = 1'b1; data16 = 32'h1600 + 32'(k); acceptDrv16 = 1'b1;
      sb16.push_back(modelWrite(k, 4, 2, 1'b1, 32'h1600 + 32'(k)));
      @(posedge clk); #1;
    end
    valid16 = 1'b0; acceptDrv16 = 1'b0;
    @(negedge clk);
    checkOutput("done16", 64'(done16), 64'd1);
    @(negedge clk);
    checkOutput("sb16Drained", 64'(sb16.size()), 64'd0);
    checkOutput("busy16Idle", 64'(busy16), 64'd0);

    $display("[TB] random valid gaps");
    applyStimulus(1'b1, 32'h5500_0000, 3, 1'b0, 8);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 32'h7700_0000, 0, 1'b0, 3);
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midReset");
    checkOutput("sbAfterAbort", 64'(sb8.size()), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    applyStimulus(1'b1, 32'd0, 0, 1'b0, 8);

    $display("[TB] start and mode disturbances mid-frame");
    applyStimulus(1'b1, 32'h3300_0000, 2, 1'b1, 8);
    applyStimulus(1'b0, 32'h4400_0000, 2, 1'b1, 8);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
